// File: rtl/pong_ball_engine.sv
// Pong ball engine: per-frame ball motion, wall/paddle bounces,
// miss detection, scoring and serve/score/game-over sequencing.
module pong_ball_engine #(
  parameter int H_SIZE        = 8,
  parameter int V_SIZE        = 8,
  parameter int IX            = 320,
  parameter int IY            = 240,
  parameter int D_WIDTH       = 640,
  parameter int D_HEIGHT      = 480,
  parameter int BAR_WIDTH     = 20,
  parameter int BAR_HEIGHT    = 80,
  parameter int SPEED_INIT    = 2,
  parameter int SPEED_MAX     = 6,
  parameter int HITS_PER_STEP = 4,
  parameter int SERVE_DELAY   = 60,
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 9
) (
  input  logic               in_clock,
  input  logic               in_reset,
  input  logic               in_ani_stb,
  input  logic               in_animate,
  input  logic               in_serve,
  input  logic [11:0]        in_left_bar_top,
  input  logic [11:0]        in_right_bar_top,
  output logic [11:0]        out_x1,
  output logic [11:0]        out_x2,
  output logic [11:0]        out_y1,
  output logic [11:0]        out_y2,
  output logic [SCORE_W-1:0] out_left_score,
  output logic [SCORE_W-1:0] out_right_score,
  output logic               out_point,
  output logic               out_game_over,
  output logic [1:0]         out_state
);

  typedef enum logic [1:0] {
    S_SERVE  = 2'd0,
    S_PLAY   = 2'd1,
    S_SCORED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [12:0] HS = 13'(H_SIZE);
  localparam logic [12:0] VS = 13'(V_SIZE);
  localparam logic [12:0] DW = 13'(D_WIDTH);
  localparam logic [12:0] DH = 13'(D_HEIGHT);
  localparam logic [12:0] BW = 13'(BAR_WIDTH);
  localparam logic [12:0] BH = 13'(BAR_HEIGHT);

  localparam logic [11:0] C_HS  = 12'(H_SIZE);
  localparam logic [11:0] C_VS  = 12'(V_SIZE);
  localparam logic [11:0] C_IX  = 12'(IX);
  localparam logic [11:0] C_IY  = 12'(IY);
  localparam logic [11:0] C_YB  = 12'(D_HEIGHT - V_SIZE);
  localparam logic [11:0] C_XL  = 12'(BAR_WIDTH + H_SIZE);
  localparam logic [11:0] C_XR  = 12'(D_WIDTH - BAR_WIDTH - H_SIZE);
  localparam logic [11:0] C_SI  = 12'(SPEED_INIT);
  localparam logic [11:0] C_SM  = 12'(SPEED_MAX);
  localparam logic [11:0] C_HP  = 12'(HITS_PER_STEP);
  localparam logic [11:0] C_SD  = 12'(SERVE_DELAY);
  localparam logic [SCORE_W-1:0] C_WIN = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] C_TOP = {SCORE_W{1'b1}};

  state_t             r_state;
  logic [11:0]        r_x;
  logic [11:0]        r_y;
  logic               r_x_dir;
  logic               r_y_dir;
  logic [11:0]        r_speed;
  logic [11:0]        r_hits;
  logic [11:0]        r_delay;
  logic [SCORE_W-1:0] r_left_score;
  logic [SCORE_W-1:0] r_right_score;
  logic               r_point;

  logic        w_tick;
  logic [12:0] w_x;
  logic [12:0] w_y;
  logic [12:0] w_s;
  logic [12:0] w_top;
  logic        w_edge;
  logic        w_hit;
  logic [11:0] w_y_nxt;
  logic        w_y_dir_nxt;
  logic [11:0] w_hits_inc;

  assign w_tick     = in_ani_stb & in_animate;
  assign w_x        = {1'b0, r_x};
  assign w_y        = {1'b0, r_y};
  assign w_s        = {1'b0, r_speed};
  assign w_top      = {1'b0, r_x_dir ? in_right_bar_top : in_left_bar_top};
  assign w_hits_inc = r_hits + 12'd1;

  // Subtractions only happen after the clamp test, so nothing underflows.
  assign w_edge = r_x_dir ? (w_x + HS + w_s >= DW - BW)
                          : (w_x - HS <= BW + w_s);
  assign w_hit  = (w_y + VS >= w_top) && (w_y - VS <= w_top + BH);

  always_comb begin
    w_y_nxt     = r_y;
    w_y_dir_nxt = r_y_dir;
    if (!r_y_dir) begin
      if (w_y - VS <= w_s) begin
        w_y_nxt     = C_VS;
        w_y_dir_nxt = 1'b1;
      end else begin
        w_y_nxt = r_y - r_speed;
      end
    end else begin
      if (w_y + VS + w_s >= DH) begin
        w_y_nxt     = C_YB;
        w_y_dir_nxt = 1'b0;
      end else begin
        w_y_nxt = r_y + r_speed;
      end
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_state       <= S_SERVE;
      r_x           <= C_IX;
      r_y           <= C_IY;
      r_x_dir       <= 1'b1;
      r_y_dir       <= 1'b0;
      r_speed       <= C_SI;
      r_hits        <= '0;
      r_delay       <= '0;
      r_left_score  <= '0;
      r_right_score <= '0;
      r_point       <= 1'b0;
    end else begin
      r_point <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          S_SERVE: begin
            if (in_serve) r_state <= S_PLAY;
          end
          S_PLAY: begin
            r_y     <= w_y_nxt;
            r_y_dir <= w_y_dir_nxt;
            if (!w_edge) begin
              r_x <= r_x_dir ? r_x + r_speed : r_x - r_speed;
            end else if (w_hit) begin
              r_x     <= r_x_dir ? C_XR : C_XL;
              r_x_dir <= ~r_x_dir;
              if (w_hits_inc >= C_HP) begin
                r_hits  <= '0;
                r_speed <= (r_speed >= C_SM) ? C_SM : r_speed + 12'd1;
              end else begin
                r_hits <= w_hits_inc;
              end
            end else begin
              if (r_x_dir) begin
                if (r_left_score != C_TOP) r_left_score <= r_left_score + 1'b1;
              end else begin
                if (r_right_score != C_TOP) r_right_score <= r_right_score + 1'b1;
              end
              r_point <= 1'b1;
              r_delay <= C_SD;
              r_state <= S_SCORED;
            end
          end
          S_SCORED: begin
            // x_dir is untouched: it still points at the conceding side.
            if (r_delay <= 12'd1) begin
              r_delay <= '0;
              r_x     <= C_IX;
              r_y     <= C_IY;
              r_speed <= C_SI;
              r_hits  <= '0;
              r_y_dir <= 1'b0;
              r_state <= (r_left_score == C_WIN || r_right_score == C_WIN)
                         ? S_OVER : S_SERVE;
            end else begin
              r_delay <= r_delay - 12'd1;
            end
          end
          S_OVER: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign out_x1          = r_x - C_HS;
  assign out_x2          = r_x + C_HS;
  assign out_y1          = r_y - C_VS;
  assign out_y2          = r_y + C_VS;
  assign out_left_score  = r_left_score;
  assign out_right_score = r_right_score;
  assign out_point       = r_point;
  assign out_game_over   = (r_state == S_OVER);
  assign out_state       = r_state;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: vector table, directed rallies,
// and random play checked against an integer ball model.
module tb_pong_ball_engine;

  logic        in_clock = 1'b0;
  logic        in_reset = 1'b1;
  logic        in_ani_stb = 1'b0;
  logic        in_animate = 1'b0;
  logic        in_serve = 1'b0;
  logic [11:0] in_left_bar_top = '0;
  logic [11:0] in_right_bar_top = '0;
  logic [11:0] out_x1, out_x2, out_y1, out_y2;
  logic [3:0]  out_left_score, out_right_score;
  logic        out_point, out_game_over;
  logic [1:0]  out_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: ball centre, unit direction, speed, rally hits, scores.
  int mx, my, mvx, mvy, mspd, mhits, mls, mrs, mdel, mst, mpt;

  pong_ball_engine dut (
    .in_clock(in_clock),
    .in_reset(in_reset),
    .in_ani_stb(in_ani_stb),
    .in_animate(in_animate),
    .in_serve(in_serve),
    .in_left_bar_top(in_left_bar_top),
    .in_right_bar_top(in_right_bar_top),
    .out_x1(out_x1),
    .out_x2(out_x2),
    .out_y1(out_y1),
    .out_y2(out_y2),
    .out_left_score(out_left_score),
    .out_right_score(out_right_score),
    .out_point(out_point),
    .out_game_over(out_game_over),
    .out_state(out_state)
  );

  always #5 in_clock = ~in_clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit stb, input bit anim,
                            input bit srv, input int lt, input int rt);
    int s, ny, nvy, top;
    bit reach;
    if (rst) begin
      mx = 320; my = 240; mvx = 1; mvy = -1; mspd = 2; mhits = 0;
      mls = 0; mrs = 0; mdel = 0; mst = 0; mpt = 0;
    end else begin
      mpt = 0;
      if (stb && anim) begin
        case (mst)
          0: if (srv) mst = 1;
          1: begin
            s = mspd;
            if (mvy < 0) begin
              if (my - 8 <= s) begin ny = 8; nvy = 1; end
              else begin ny = my - s; nvy = -1; end
            end else begin
              if (my + 8 + s >= 480) begin ny = 472; nvy = -1; end
              else begin ny = my + s; nvy = 1; end
            end
            top = (mvx > 0) ? rt : lt;
            reach = (mvx < 0) ? (mx - 8 <= 20 + s) : (mx + 8 + s >= 620);
            if (!reach) mx = mx + mvx * s;
            else if (my + 8 >= top && my - 8 <= top + 80) begin
              mx = (mvx > 0) ? 612 : 28;
              mvx = -mvx;
              mhits++;
              if (mhits == 4) begin
                mhits = 0;
                if (mspd < 6) mspd++;
              end
            end else begin
              if (mvx < 0) begin if (mrs < 15) mrs++; end
              else begin if (mls < 15) mls++; end
              mpt = 1; mdel = 60; mst = 2;
            end
            my = ny; mvy = nvy;
          end
          2: begin
            mdel--;
            if (mdel == 0) begin
              mx = 320; my = 240; mspd = 2; mhits = 0; mvy = -1;
              mst = (mls == 9 || mrs == 9) ? 3 : 0;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_model();
    chk("x1", int'(out_x1), mx - 8);
    chk("x2", int'(out_x2), mx + 8);
    chk("y1", int'(out_y1), my - 8);
    chk("y2", int'(out_y2), my + 8);
    chk("left_score", int'(out_left_score), mls);
    chk("right_score", int'(out_right_score), mrs);
    chk("point", int'(out_point), mpt);
    chk("state", int'(out_state), mst);
    chk("game_over", int'(out_game_over), (mst == 3) ? 1 : 0);
  endtask

  task automatic cyc(input bit rst, input bit stb, input bit anim,
                     input bit srv, input int lt, input int rt);
    in_reset = rst; in_ani_stb = stb; in_animate = anim; in_serve = srv;
    in_left_bar_top = 12'(lt); in_right_bar_top = 12'(rt);
    @(posedge in_clock);
    model_step(rst, stb, anim, srv, lt, rt);
    #1;
    check_model();
  endtask

  task automatic tk(input bit srv, input int lt, input int rt);
    cyc(1'b0, 1'b1, 1'b1, srv, lt, rt);
  endtask

  function automatic int trk();
    int t;
    t = my - 20;
    if (t < 0) t = 0;
    return t;
  endfunction

  typedef struct {
    bit stb; bit anim; bit srv;
    int x1; int y1; int st;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int px, d, nh, rl, rr, j;
    bit c4, c16, c20, got;

    tbl[0] = '{1, 1, 0, 312, 232, 0};
    tbl[1] = '{0, 1, 1, 312, 232, 0};
    tbl[2] = '{1, 1, 1, 312, 232, 1};
    tbl[3] = '{1, 1, 0, 314, 230, 1};
    tbl[4] = '{1, 1, 0, 316, 228, 1};
    tbl[5] = '{1, 0, 0, 316, 228, 1};
    tbl[6] = '{0, 1, 0, 316, 228, 1};
    tbl[7] = '{1, 1, 1, 318, 226, 1};

    cyc(1, 0, 0, 0, 200, 200);
    chk("reset x1", int'(out_x1), 312);
    chk("reset y1", int'(out_y1), 232);
    chk("reset state", int'(out_state), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, tbl[i].stb, tbl[i].anim, tbl[i].srv, 200, 200);
      chk($sformatf("vec%0d x1", i), int'(out_x1), tbl[i].x1);
      chk($sformatf("vec%0d y1", i), int'(out_y1), tbl[i].y1);
      chk($sformatf("vec%0d state", i), int'(out_state), tbl[i].st);
    end

    // Top wall: ball bottoms at y=8 on tick 116 and turns down.
    cyc(1, 0, 0, 0, 0, 0);
    tk(1, 0, 0);
    px = 4095;
    for (int i = 1; i <= 130; i++) begin
      tk(0, trk(), trk());
      if (int'(out_y1) < px) px = int'(out_y1);
    end
    chk("wall min y1", px, 0);
    chk("wall y1 after 130", int'(out_y1), 28);
    chk("wall x1 after 130", int'(out_x1), 572);

    // Right paddle contact clamps x2 to the face.
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tk(0, trk(), trk());
      if (int'(out_x2) >= 619) got = 1;
    end
    chk("right contact reached", int'(got), 1);
    chk("right clamp x2", int'(out_x2), 620);
    tk(0, trk(), trk());
    chk("x_dir left after hit", int'(out_x2), 618);

    // Rally speed-up: +1 per 4 hits, capped at 6.
    nh = 1; c4 = 0; c16 = 0; c20 = 0; px = int'(out_x1);
    for (int i = 0; i < 5000 && !c20; i++) begin
      tk(0, trk(), trk());
      if (out_x1 == 12'd20 || out_x2 == 12'd620) nh++;
      else begin
        d = int'(out_x1) - px;
        if (d < 0) d = -d;
        if (nh == 4 && !c4) begin chk("speed after 4 hits", d, 3); c4 = 1; end
        if (nh == 16 && !c16) begin chk("speed after 16 hits", d, 6); c16 = 1; end
        if (nh == 20 && !c20) begin chk("speed capped", d, 6); c20 = 1; end
      end
      px = int'(out_x1);
    end
    chk("rally reached 20 hits", int'(c20), 1);

    // Miss on the right: left scores, one-cycle point pulse, 60-tick hold.
    cyc(1, 0, 0, 0, 400, 400);
    tk(1, 400, 400);
    for (int i = 0; i < 200 && out_state != 2'd2; i++) tk(0, 400, 400);
    chk("miss -> SCORED", int'(out_state), 2);
    chk("point high", int'(out_point), 1);
    chk("left score 1", int'(out_left_score), 1);
    chk("right score 0", int'(out_right_score), 0);
    cyc(0, 0, 1, 0, 400, 400);
    chk("point one cycle", int'(out_point), 0);
    for (int i = 0; i < 59; i++) tk(0, 400, 400);
    chk("SCORED after 59", int'(out_state), 2);
    tk(0, 400, 400);
    chk("SERVE after 60", int'(out_state), 0);
    chk("serve x1", int'(out_x1), 312);
    chk("serve y1", int'(out_y1), 232);
    tk(1, 400, 400);
    tk(0, 400, 400);
    chk("relaunch toward right", int'(out_x1), 314);

    // Left keeps scoring until the game ends.
    for (int r = 0; r < 12 && out_state != 2'd3; r++) begin
      tk(1, 400, 400);
      for (int i = 0; i < 200 && out_state == 2'd1; i++) tk(0, 400, 400);
      for (int i = 0; i < 70 && out_state == 2'd2; i++) tk(0, 400, 400);
    end
    chk("win score", int'(out_left_score), 9);
    chk("GAME_OVER state", int'(out_state), 3);
    chk("game_over flag", int'(out_game_over), 1);
    for (int i = 0; i < 3; i++) tk(1, 400, 400);
    chk("serve ignored state", int'(out_state), 3);
    chk("serve ignored x1", int'(out_x1), 312);

    // Reset with a coincident tick, in the middle of SCORED.
    cyc(1, 0, 0, 0, 400, 400);
    tk(1, 400, 400);
    for (int i = 0; i < 200 && out_state != 2'd2; i++) tk(0, 400, 400);
    for (int i = 0; i < 10; i++) tk(0, 400, 400);
    chk("mid SCORED", int'(out_state), 2);
    cyc(1, 1, 1, 1, 400, 400);
    chk("rst state", int'(out_state), 0);
    chk("rst x1", int'(out_x1), 312);
    chk("rst y1", int'(out_y1), 232);
    chk("rst left score", int'(out_left_score), 0);
    chk("rst point", int'(out_point), 0);

    // Random play against the model.
    for (int i = 0; i < 15000; i++) begin
      j = $urandom_range(0, 9);
      rl = (j < 7) ? my - 20 + $urandom_range(0, 120) - 60 : $urandom_range(0, 400);
      j = $urandom_range(0, 9);
      rr = (j < 7) ? my - 20 + $urandom_range(0, 120) - 60 : $urandom_range(0, 400);
      if (rl < 0) rl = 0;
      if (rr < 0) rr = 0;
      got = ($urandom_range(0, 2999) == 0) ||
            (mst == 3 && $urandom_range(0, 199) == 0);
      cyc(got, $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 3) == 0, rl, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
